// File: rtl/mul_share_arb_if.sv
// mul_share_arb_if: requester handshake, response and multiplier bus for mul_share_arb
interface mul_share_arb_if #(
    parameter int NUM_REQ = 4
);
    logic [NUM_REQ-1:0]   req_valid;
    logic [NUM_REQ-1:0]   req_ready;
    logic [NUM_REQ*8-1:0] req_a;
    logic [NUM_REQ*8-1:0] req_b;
    logic [NUM_REQ-1:0]   rsp_valid;
    logic [15:0]          rsp_data;
    logic                 mul_en_in;
    logic [7:0]           mul_a;
    logic [7:0]           mul_b;
    logic                 mul_en_out;
    logic [15:0]          mul_out;
    modport master (
        output req_valid, req_a, req_b, mul_en_out, mul_out,
        input  req_ready, rsp_valid, rsp_data, mul_en_in, mul_a, mul_b
    );
    modport slave (
        input  req_valid, req_a, req_b, mul_en_out, mul_out,
        output req_ready, rsp_valid, rsp_data, mul_en_in, mul_a, mul_b
    );
endinterface

// File: rtl/mul_share_arb.sv
// mul_share_arb: round-robin sharing of one pipelined multiplier; MUL_ARB_STATS_EN adds issue_cnt
module mul_share_arb #(
    parameter int NUM_REQ = 4,
    parameter int MUL_LAT = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    mul_share_arb_if.slave    bus,
    output logic              idle,
    output logic              err
`ifdef MUL_ARB_STATS_EN
    ,
    output logic [15:0]       issue_cnt
`endif
);
    localparam int IW = NUM_REQ > 1 ? $clog2(NUM_REQ) : 1;
    logic [IW-1:0] rr_ptr, win, idx, iss_idx;
    logic hit, go;
    logic [MUL_LAT-1:0] tag_v;
    logic [MUL_LAT-1:0][IW-1:0] tag_i;
    always_comb begin
        win = rr_ptr;
        idx = rr_ptr;
        hit = 1'b0;
        for (int j = NUM_REQ - 1; j >= 0; j--) begin
            idx = IW'((int'(rr_ptr) + j) % NUM_REQ);
            if (bus.req_valid[idx]) begin
                win = idx;
                hit = 1'b1;
            end
        end
    end
    assign go = en & rst_n & hit;
    assign bus.req_ready = go ? NUM_REQ'(1) << win : '0;
    assign idle = !bus.mul_en_in && !(|tag_v) && !(|bus.rsp_valid);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr        <= '0;
            iss_idx       <= '0;
            bus.mul_en_in <= 1'b0;
            bus.mul_a     <= '0;
            bus.mul_b     <= '0;
            tag_v         <= '0;
            tag_i         <= '0;
            bus.rsp_valid <= '0;
            bus.rsp_data  <= '0;
            err           <= 1'b0;
        end else begin
            if (go) rr_ptr <= (win == IW'(NUM_REQ - 1)) ? '0 : win + 1'b1;
            iss_idx       <= win;
            bus.mul_en_in <= go;
            bus.mul_a     <= go ? bus.req_a[win*8 +: 8] : '0;
            bus.mul_b     <= go ? bus.req_b[win*8 +: 8] : '0;
            tag_v[0]      <= bus.mul_en_in;
            tag_i[0]      <= iss_idx;
            for (int k = 1; k < MUL_LAT; k++) begin
                tag_v[k] <= tag_v[k-1];
                tag_i[k] <= tag_i[k-1];
            end
            bus.rsp_valid <= tag_v[MUL_LAT-1] ? NUM_REQ'(1) << tag_i[MUL_LAT-1] : '0;
            if (tag_v[MUL_LAT-1]) bus.rsp_data <= bus.mul_out;
            err <= err | (bus.mul_en_out != tag_v[MUL_LAT-1]);
        end
    end
`ifdef MUL_ARB_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) issue_cnt <= '0;
        else if (bus.mul_en_in && issue_cnt != 16'hFFFF) issue_cnt <= issue_cnt + 16'd1;
    end
`endif
endmodule

// File: tb/tb_mul_share_arb.sv
// tb_mul_share_arb: randomized and directed checks of mul_share_arb against a scoreboard model
module tb_mul_share_arb;
    localparam int NR  = 4;
    localparam int LAT = 4;
    typedef struct {
        int idx;
        int prod;
        int due;
    } item_t;
    logic clk, rst_n, en, idle, err, force_en;
`ifdef MUL_ARB_STATS_EN
    logic [15:0] issue_cnt;
`endif
    mul_share_arb_if #(.NUM_REQ(NR)) bus ();
    mul_share_arb #(.NUM_REQ(NR), .MUL_LAT(LAT)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .en(en),
        .bus(bus),
        .idle(idle),
        .err(err)
`ifdef MUL_ARB_STATS_EN
        ,
        .issue_cnt(issue_cnt)
`endif
    );
    logic [LAT-1:0] pv;
    logic [LAT-1:0][15:0] pp;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pv <= '0;
            pp <= '0;
        end else begin
            pv <= {pv[LAT-2:0], bus.mul_en_in};
            pp <= {pp[LAT-2:0], {8'd0, bus.mul_a} * {8'd0, bus.mul_b}};
        end
    end
    assign bus.mul_en_out = pv[LAT-1] | force_en;
    assign bus.mul_out = pp[LAT-1];
    initial clk = 1'b0;
    always #5 clk = ~clk;
    int total, bad, cyc, rr, hs, last_rsp, g;
    logic prev_go, exp_err;
    logic [7:0] prev_a, prev_b;
    item_t sb[$];
    logic [NR-1:0] cv;
    logic [NR*8-1:0] ca, cb;
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask
    task automatic drive(input logic e, input logic [NR-1:0] v, input logic [NR*8-1:0] a,
                         input logic [NR*8-1:0] b, output int gr);
        logic [NR-1:0] exp_rv;
        @(negedge clk);
        cyc++;
        exp_rv = '0;
        if (sb.size() > 0 && sb[0].due == cyc) begin
            exp_rv[sb[0].idx] = 1'b1;
            last_rsp = sb[0].prod;
            void'(sb.pop_front());
        end
        check("rsp_valid", 32'(bus.rsp_valid), 32'(exp_rv));
        check("rsp_data", 32'(bus.rsp_data), last_rsp);
        check("mul_en_in", 32'(bus.mul_en_in), 32'(prev_go));
        check("mul_a", 32'(bus.mul_a), 32'(prev_a));
        check("mul_b", 32'(bus.mul_b), 32'(prev_b));
        check("idle", 32'(idle), 32'(sb.size() == 0 && exp_rv == '0));
        check("err", 32'(err), 32'(exp_err));
        en = e;
        bus.req_valid = v;
        bus.req_a = a;
        bus.req_b = b;
        #1;
        gr = -1;
        if (e)
            for (int j = 0; j < NR && gr < 0; j++)
                if (v[(rr + j) % NR]) gr = (rr + j) % NR;
        check("req_ready", 32'(bus.req_ready), gr < 0 ? 32'd0 : 32'd1 << gr);
        prev_go = gr >= 0;
        prev_a = '0;
        prev_b = '0;
        if (gr >= 0) begin
            prev_a = a[gr*8 +: 8];
            prev_b = b[gr*8 +: 8];
            sb.push_back('{gr, int'(prev_a) * int'(prev_b), cyc + LAT + 2});
            rr = (gr + 1) % NR;
            hs++;
        end
    endtask
    task automatic drain(input int n);
        int d;
        repeat (n) drive(1'b1, '0, '0, '0, d);
    endtask
    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        en = 1'b1;
        bus.req_valid = '1;
        #1;
        check("rst_req_ready", 32'(bus.req_ready), 0);
        check("rst_mul_en_in", 32'(bus.mul_en_in), 0);
        check("rst_mul_a", 32'(bus.mul_a), 0);
        check("rst_mul_b", 32'(bus.mul_b), 0);
        check("rst_rsp_valid", 32'(bus.rsp_valid), 0);
        check("rst_rsp_data", 32'(bus.rsp_data), 0);
        check("rst_idle", 32'(idle), 1);
        check("rst_err", 32'(err), 0);
`ifdef MUL_ARB_STATS_EN
        check("rst_issue_cnt", 32'(issue_cnt), 0);
`endif
        sb.delete();
        rr = 0;
        hs = 0;
        prev_go = 1'b0;
        prev_a = '0;
        prev_b = '0;
        last_rsp = 0;
        exp_err = 1'b0;
        force_en = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        bus.req_valid = '0;
    endtask
    initial begin
        rst_n = 1'b1;
        en = 1'b0;
        force_en = 1'b0;
        bus.req_valid = '0;
        bus.req_a = '0;
        bus.req_b = '0;
        total = 0;
        bad = 0;
        cyc = 0;
        do_reset();
        drain(2);
        drive(1'b1, 4'b0100, {8'd0, 8'd13, 16'd0}, {8'd0, 8'd11, 16'd0}, g);
        drain(8);
        do_reset();
        repeat (8) drive(1'b1, 4'b1111, {8'd100, 8'd13, 8'd0, 8'd255}, {8'd3, 8'd7, 8'd200, 8'd255}, g);
        drain(8);
        for (int i = 0; i < 3; i++)
            drive(1'b1, 4'b0010, {8'd0, 8'd0, 8'(i * 40 + 7), 8'd0}, {8'd0, 8'd0, 8'(i + 9), 8'd0}, g);
        drain(8);
        repeat (2) drive(1'b1, 4'b1111, {8'd5, 8'd6, 8'd7, 8'd8}, {8'd9, 8'd10, 8'd11, 8'd12}, g);
        repeat (10) drive(1'b0, 4'b1111, {8'd5, 8'd6, 8'd7, 8'd8}, {8'd9, 8'd10, 8'd11, 8'd12}, g);
        drain(2);
        drive(1'b1, 4'b0001, {24'd0, 8'd77}, {24'd0, 8'd3}, g);
        drain(1);
        do_reset();
        drain(10);
        cv = '0;
        ca = '0;
        cb = '0;
        repeat (300) begin
            for (int i = 0; i < NR; i++)
                if (!cv[i]) begin
                    cv[i] = 1'($urandom_range(0, 1));
                    ca[i*8 +: 8] = 8'($urandom);
                    cb[i*8 +: 8] = 8'($urandom);
                end
            drive($urandom_range(0, 7) != 0, cv, ca, cb, g);
            if (g >= 0) cv[g] = 1'b0;
        end
        drain(10);
        check("sb_empty", sb.size(), 0);
`ifdef MUL_ARB_STATS_EN
        check("issue_cnt", 32'(issue_cnt), hs);
`endif
        force_en = 1'b1;
        exp_err = 1'b1;
        drain(1);
        force_en = 1'b0;
        drain(4);
        do_reset();
        drain(2);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/mul_share_arb.md
# mul_share_arb

Round-robin arbiter and sequencer that shares one pipelined 8x8 multiplier among NUM_REQ requesters. It accepts operand pairs on per-requester valid/ready handshakes and issues at most one operation per cycle to the multiplier. A tag pipeline tracks which requester owns each in-flight operation, and each product is routed back to its owner. The block sits between the requester clients and the multiplier instance, and drives the multiplier's `mul_en_in`/`mul_a`/`mul_b`.

## Interface
- NUM_REQ, 4: number of requesters, 2..8.
- MUL_LAT, 4: cycles from `mul_en_in` high to the matching `mul_en_out`/`mul_out` at the multiplier output.
- clk  input  1  clock.
- rst_n  input  1  reset, asynchronous, active-low.
- en  input  1  issue enable; low blocks new grants while in-flight operations drain.
- req_valid  input  NUM_REQ  per-requester operand valid.
- req_a  input  NUM_REQ*8  operand A; requester i uses bits [8i+7:8i].
- req_b  input  NUM_REQ*8  operand B; same packing as req_a.
- req_ready  output  NUM_REQ  one-hot grant (or zero), combinational.
- mul_en_in  output  1  issue strobe to the multiplier, registered.
- mul_a, mul_b  output  8 each  operands to the multiplier, registered.
- mul_en_out  input  1  multiplier result valid.
- mul_out  input  16  multiplier product.
- rsp_valid  output  NUM_REQ  one-hot result strobe, registered, one-cycle pulse.
- rsp_data  output  16  product for the requester flagged in rsp_valid.
- idle  output  1  high when no operation is in flight and no issue is pending.
- err  output  1  sticky; set on a tag/`mul_en_out` mismatch.
- issue_cnt  output  16  saturating count of issued operations; present only with MUL_ARB_STATS_EN.

## Operation
- Grant:
  - When `en`=1, `req_ready[i]`=1 for the first asserted `req_valid` found searching from `rr_ptr` upward, modulo NUM_REQ.
  - Handshake on requester i = `req_valid[i] & req_ready[i]`.
- Pointer update:
  - On a handshake by requester i, `rr_ptr` <= (i+1) mod NUM_REQ.
  - With no handshake, `rr_ptr` holds.
- Issue:
  - A handshake in cycle T drives `mul_en_in`=1 in cycle T+1, with `mul_a`/`mul_b` set to the winner's operands.
  - With no handshake, `mul_en_in`=0 and `mul_a`/`mul_b`=0.
- Tag pipeline:
  - MUL_LAT stages of {valid, index}, loaded alongside `mul_en_in` and shifted every cycle.
  - The last stage is aligned with the multiplier output cycle.
- Return:
  - When the last tag stage is valid with index k, the next cycle shows `rsp_valid[k]`=1 and `rsp_data`=`mul_out`.
  - Otherwise `rsp_valid`=0 and `rsp_data` holds its last value.
- Result consumption: requesters cannot stall results; every result is presented exactly once.
- Error check:
  - Whenever `mul_en_out` differs from the last-stage tag valid, `err` <= 1, and it stays set until reset.
  - Routing follows the tag, never `mul_en_out`.
- Idle: `idle` = no valid in the issue register, no valid in any tag stage, and `rsp_valid`=0.
- Enable: `en` low does not flush; in-flight results still return.
- Product width: 16 bits; the block passes `mul_out` unmodified.

## Timing
- Reset values:
  - `req_ready`=0 while in reset.
  - `mul_en_in`=0, `mul_a`=0, `mul_b`=0.
  - `rsp_valid`=0, `rsp_data`=0.
  - `idle`=1, `err`=0, `issue_cnt`=0.
  - `rr_ptr`=0, all tag stages invalid.
- Latency: handshake in cycle T gives `rsp_valid` in cycle T+MUL_LAT+2 (6 with default MUL_LAT).
- Throughput: one grant per cycle; back-to-back handshakes by different requesters return in the same order, one per cycle.
- Simultaneous requests: exactly one grant per cycle; the others wait with `req_ready`=0, and their operands must be held stable.
- Reset mid-operation: all in-flight operations are discarded, and no `rsp_valid` is produced for them after reset release.
- `en` deasserted in the same cycle as `req_valid`: no grant in that cycle.

## Configuration
- MUL_ARB_STATS_EN defined:
  - `issue_cnt` port exists.
  - It increments on each `mul_en_in`=1 cycle and saturates at 16'hFFFF.
- MUL_ARB_STATS_EN undefined: port and counter are absent; all other behaviour is identical.

## Test plan
- Single request: req 2, a=8'd13, b=8'd11 → `req_ready`=4'b0100 in the same cycle; `rsp_valid`=4'b0100 six cycles later with `rsp_data`=16'd143.
- All four valid every cycle from reset → grants in order 0,1,2,3,0,…; products return in that order, one per cycle. Check 255x255=16'd65025 and 0x200=0.
- Same requester back-to-back (req 1 alone, 3 consecutive handshakes) → grants every cycle and 3 consecutive `rsp_valid[1]` pulses.
- `en`=0 with 2 operations in flight → no new `req_ready`; both results return; `idle` rises the cycle after the last `rsp_valid`.
- Reset asserted 2 cycles after a handshake → no `rsp_valid` after release; all outputs at their reset values.
- Multiplier model forces `mul_en_out`=1 with no tag valid → `err`=1 next cycle and sticky until reset. With MUL_ARB_STATS_EN defined, `issue_cnt` equals the number of handshakes.
